// File: rtl/mm_requant_pkg.sv
// Shared widths and the int8 clamp used by the requantize/pack stage.
package mm_requant_pkg;

  localparam int D_W     = 8;
  localparam int D_W_ACC = 32;
  localparam int PACK    = 4;
  localparam int SHIFT_W = 6;
  localparam int PROD_W  = 64;
  localparam int SUM_W   = PROD_W + 2;
  localparam int OUT_W   = PACK * D_W;
  localparam int LANE_W  = $clog2(PACK);

  localparam logic signed [SUM_W-1:0] SAT_MAX = 127;
  localparam logic signed [SUM_W-1:0] SAT_MIN = -128;

  // Clamp a wide signed value into the int8 range.
  function automatic logic signed [D_W-1:0] sat_int8(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX) begin
      return 8'sh7F;
    end else if (v < SAT_MIN) begin
      return 8'sh80;
    end else begin
      return v[D_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mm_requant_pack_packer.sv
// Collects int8 results into 32-bit words and owns the output AXI-S register.
// The output register only loads when it is empty or being drained this cycle,
// which is exactly when adv is high.
module rq_packer
  import mm_requant_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  elem_vld,
  input  logic signed [D_W-1:0] elem,
  input  logic                  elem_last,
  input  logic                  tready,
  output logic                  adv,
  output logic [OUT_W-1:0]      tdata,
  output logic [PACK-1:0]       tkeep,
  output logic                  tvalid,
  output logic                  tlast
);

  logic [LANE_W-1:0] lane;
  logic [OUT_W-1:0]  word;
  logic [OUT_W-1:0]  word_next;
  logic [OUT_W-1:0]  word_masked;
  logic [PACK-1:0]   keep_next;
  logic              emit;

  assign adv  = ~(tvalid & ~tready);
  assign emit = elem_vld & ((lane == LANE_W'(PACK-1)) | elem_last);

  // Merge the incoming element into its lane and blank lanes beyond it.
  always_comb begin
    word_next   = word;
    word_masked = '0;
    keep_next   = '0;
    for (int i = 0; i < PACK; i++) begin
      if (LANE_W'(i) == lane) begin
        word_next[i*D_W +: D_W] = elem;
      end
      keep_next[i] = (LANE_W'(i) <= lane);
    end
    for (int i = 0; i < PACK; i++) begin
      if (keep_next[i]) begin
        word_masked[i*D_W +: D_W] = word_next[i*D_W +: D_W];
      end
    end
  end

  // Word accumulator: stale lanes are masked at emit time, so no reset needed.
  always_ff @(posedge clk) begin
    if (adv && elem_vld) begin
      word <= word_next;
    end
  end

  // Lane counter and output register with the AXI-S handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane   <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      tkeep  <= '0;
      tdata  <= '0;
    end else if (adv) begin
      if (emit) begin
        tvalid <= 1'b1;
        tdata  <= word_masked;
        tkeep  <= keep_next;
        tlast  <= elem_last;
        lane   <= '0;
      end else begin
        tvalid <= 1'b0;
        if (elem_vld) begin
          lane <= lane + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mm_requant_pack.sv
// Requantizes the int32 accumulator stream to int8 (scale, rounding shift,
// zero point, saturate) and packs four results per 32-bit output beat.
// A single stall derived from the output register freezes the whole pipe.
module mm_requant_pack
  import mm_requant_pkg::*;
(
  input  logic                      mm_clk,
  input  logic                      mm_rst_n,
  input  logic signed [D_W_ACC-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [OUT_W-1:0]          m_axis_tdata,
  output logic [PACK-1:0]           m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  input  logic signed [31:0]        M0,
  input  logic [SHIFT_W-1:0]        SHIFT,
  input  logic signed [D_W-1:0]     ZP
);

  localparam logic signed [SUM_W-1:0] RND_ONE = 1;

  // Rounding arithmetic right shift (ties toward +inf), zero point, clamp.
  function automatic logic signed [D_W-1:0] requant(
    input logic signed [PROD_W-1:0] prod,
    input logic [SHIFT_W-1:0]       sh,
    input logic signed [D_W-1:0]    zp
  );
    logic signed [SUM_W-1:0] ext;
    logic signed [SUM_W-1:0] rnd;
    logic signed [SUM_W-1:0] r;
    ext = SUM_W'(prod);
    if (sh == '0) begin
      r = ext;
    end else begin
      rnd = RND_ONE <<< (sh - 1'b1);
      r   = (ext + rnd) >>> sh;
    end
    return sat_int8(r + SUM_W'(zp));
  endfunction

  logic adv;
  logic accept;

  logic                      first_q;
  logic signed [31:0]        m0_q;
  logic [SHIFT_W-1:0]        shift_q;
  logic signed [D_W-1:0]     zp_q;
  logic signed [31:0]        m0_eff;
  logic [SHIFT_W-1:0]        shift_eff;
  logic signed [D_W-1:0]     zp_eff;

  logic                      vld_p1;
  logic signed [PROD_W-1:0]  prod_p1;
  logic                      last_p1;
  logic [SHIFT_W-1:0]        shift_p1;
  logic signed [D_W-1:0]     zp_p1;

  logic                      vld_p2;
  logic signed [D_W-1:0]     q_p2;
  logic                      last_p2;

  assign accept        = s_axis_tvalid & adv;
  assign s_axis_tready = adv;

  // The first beat of a packet uses the live config inputs; later beats the latched copy.
  assign m0_eff    = first_q ? M0    : m0_q;
  assign shift_eff = first_q ? SHIFT : shift_q;
  assign zp_eff    = first_q ? ZP    : zp_q;

  // Latch the config on the first accepted beat of each packet.
  always_ff @(posedge mm_clk) begin
    if (!mm_rst_n) begin
      first_q <= 1'b1;
      m0_q    <= '0;
      shift_q <= '0;
      zp_q    <= '0;
    end else if (accept) begin
      first_q <= s_axis_tlast;
      if (first_q) begin
        m0_q    <= M0;
        shift_q <= SHIFT;
        zp_q    <= ZP;
      end
    end
  end

  // ---- S1: multiply ----
  // S1 valid bit.
  always_ff @(posedge mm_clk) begin
    if (!mm_rst_n) begin
      vld_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= accept;
    end
  end

  // S1 product, with the element's shift/zero point carried alongside.
  always_ff @(posedge mm_clk) begin
    if (adv) begin
      prod_p1  <= PROD_W'(s_axis_tdata) * PROD_W'(m0_eff);
      last_p1  <= s_axis_tlast;
      shift_p1 <= shift_eff;
      zp_p1    <= zp_eff;
    end
  end

  // ---- S2: round, shift, offset, saturate ----
  // S2 valid bit.
  always_ff @(posedge mm_clk) begin
    if (!mm_rst_n) begin
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p2 <= vld_p1;
    end
  end

  // S2 int8 result and last flag.
  always_ff @(posedge mm_clk) begin
    if (adv) begin
      q_p2    <= requant(prod_p1, shift_p1, zp_p1);
      last_p2 <= last_p1;
    end
  end

  // ---- Packer / output register ----
  rq_packer u_packer (
    .clk       (mm_clk),
    .rst_n     (mm_rst_n),
    .elem_vld  (vld_p2),
    .elem      (q_p2),
    .elem_last (last_p2),
    .tready    (m_axis_tready),
    .adv       (adv),
    .tdata     (m_axis_tdata),
    .tkeep     (m_axis_tkeep),
    .tvalid    (m_axis_tvalid),
    .tlast     (m_axis_tlast)
  );

endmodule

// File: tb/tb_mm_requant_pack.sv
// Directed bench for mm_requant_pack: table of whole-word packets plus
// hand-written tail, config, backpressure and reset sequences, with a
// scoreboard fed by an independent requantization model.
module tb_mm_requant_pack;

  logic               mm_clk = 1'b0;
  logic               mm_rst_n = 1'b0;
  logic signed [31:0] s_axis_tdata = '0;
  logic               s_axis_tvalid = 1'b0;
  logic               s_axis_tready;
  logic               s_axis_tlast = 1'b0;
  logic [31:0]        m_axis_tdata;
  logic [3:0]         m_axis_tkeep;
  logic               m_axis_tvalid;
  logic               m_axis_tready = 1'b1;
  logic               m_axis_tlast;
  logic signed [31:0] M0 = '0;
  logic [5:0]         SHIFT = '0;
  logic signed [7:0]  ZP = '0;

  mm_requant_pack dut (
    .mm_clk        (mm_clk),
    .mm_rst_n      (mm_rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .M0            (M0),
    .SHIFT         (SHIFT),
    .ZP            (ZP)
  );

  always #5 mm_clk = ~mm_clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int          m0;
    int          sh;
    int          zp;
    int          d0, d1, d2, d3;
    logic [31:0] exp_data;
  } vec_t;

  int errors = 0;
  int checks = 0;

  beat_t got[$];
  beat_t expq[$];
  logic [7:0] pend[$];
  bit model_first = 1'b1;
  int cm0, csh, czp;

  bit mon_en = 1'b0;
  bit bp_en = 1'b0;
  bit hold_v = 1'b0;
  beat_t hold_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Independent model: floor division of (p + half) by 2^sh.
  function automatic logic [7:0] ref_rq(input int d, input int m0, input int sh, input int zp);
    logic signed [127:0] p, den, q;
    p = longint'(d) * longint'(m0);
    if (sh == 0) begin
      q = p;
    end else begin
      den = 128'sd1 <<< sh;
      p = p + den / 2;
      q = p / den;
      if ((p % den) != 0 && p < 0) q = q - 1;
    end
    q = q + zp;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q[7:0];
  endfunction

  task automatic model_accept(input int d, input bit last);
    beat_t b;
    if (model_first) begin
      cm0 = M0; csh = int'(SHIFT); czp = ZP;
    end
    model_first = last;
    pend.push_back(ref_rq(d, cm0, csh, czp));
    if (pend.size() == 4 || last) begin
      b.data = '0; b.keep = '0; b.last = last;
      for (int i = 0; i < pend.size(); i++) begin
        b.data[8*i +: 8] = pend[i];
        b.keep[i] = 1'b1;
      end
      expq.push_back(b);
      pend.delete();
    end
  endtask

  task automatic send(input int d, input bit last);
    int n;
    bit done;
    s_axis_tdata = d; s_axis_tlast = last; s_axis_tvalid = 1'b1;
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge mm_clk);
      if (s_axis_tready) begin
        model_accept(d, last);
        done = 1'b1;
      end else if (++n > 2000) begin
        chk("send_timeout", 1, 0);
        done = 1'b1;
      end
      @(posedge mm_clk); #1;
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (n) begin @(posedge mm_clk); #1; end
  endtask

  // Output monitor: ready formula, hold stability and scoreboard.
  always @(negedge mm_clk) begin
    if (mon_en) begin
      chk("s_tready", s_axis_tready, !(m_axis_tvalid && !m_axis_tready));
      if (hold_v) begin
        chk("hold_valid", m_axis_tvalid, 1);
        chk("hold_data", {m_axis_tdata, m_axis_tkeep, m_axis_tlast},
            {hold_b.data, hold_b.keep, hold_b.last});
      end
      hold_v = m_axis_tvalid && !m_axis_tready;
      hold_b.data = m_axis_tdata; hold_b.keep = m_axis_tkeep; hold_b.last = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        got.push_back(hold_b);
        if (expq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          chk("sb_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast},
              {expq[0].data, expq[0].keep, expq[0].last});
          void'(expq.pop_front());
        end
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  // Random output backpressure.
  always @(posedge mm_clk) begin
    if (bp_en) begin
      #1 m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  vec_t tbl[5];

  initial begin
    int lat;
    tbl[0] = '{m0: 1,       sh: 1,  zp: 0,   d0: 2,   d1: 4,    d2: 6,     d3: 8,  exp_data: 32'h04030201};
    tbl[1] = '{m0: 1 << 30, sh: 31, zp: 0,   d0: 100, d1: 1000, d2: -1000, d3: -3, exp_data: 32'hFF807F32};
    tbl[2] = '{m0: 1,       sh: 1,  zp: -5,  d0: -3,  d1: 3,    d2: 0,     d3: 1,  exp_data: 32'hFCFBFDFA};
    tbl[3] = '{m0: -1,      sh: 0,  zp: 100, d0: 0,   d1: 27,   d2: 28,    d3: -50, exp_data: 32'h7F484964};
    tbl[4] = '{m0: 1,       sh: 2,  zp: 0,   d0: 2,   d1: -2,   d2: 6,     d3: -6, exp_data: 32'hFF020001};

    // Reset state.
    repeat (3) @(posedge mm_clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    mm_rst_n = 1'b1;
    @(posedge mm_clk); #1;
    chk("rst_tready", s_axis_tready, 1);
    mon_en = 1'b1;

    // Table-driven full-word packets with latency check.
    for (int v = 0; v < 5; v++) begin
      M0 = tbl[v].m0; SHIFT = 6'(tbl[v].sh); ZP = 8'(tbl[v].zp);
      got.delete();
      send(tbl[v].d0, 1'b0);
      send(tbl[v].d1, 1'b0);
      send(tbl[v].d2, 1'b0);
      send(tbl[v].d3, 1'b1);
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      lat = 0;
      while (!m_axis_tvalid && lat < 50) begin
        @(posedge mm_clk); #1; lat++;
      end
      chk("latency", lat, 2);
      idle(3);
      chk("tbl_nbeats", got.size(), 1);
      if (got.size() >= 1) begin
        chk("tbl_data", got[0].data, tbl[v].exp_data);
        chk("tbl_keep", got[0].keep, 4'hF);
        chk("tbl_last", got[0].last, 1);
      end
    end

    // Partial tail: five elements.
    M0 = 1; SHIFT = 0; ZP = 0;
    got.delete();
    for (int i = 0; i < 5; i++) send(10 + i, i == 4);
    idle(8);
    chk("tail_nbeats", got.size(), 2);
    if (got.size() >= 2) begin
      chk("tail_b1_data", got[0].data, 32'h0D0C0B0A);
      chk("tail_b1_keep", got[0].keep, 4'hF);
      chk("tail_b1_last", got[0].last, 0);
      chk("tail_b2_data", got[1].data, 32'h0000000E);
      chk("tail_b2_keep", got[1].keep, 4'h1);
      chk("tail_b2_last", got[1].last, 1);
    end

    // Config change mid-packet is ignored until after tlast.
    M0 = 1; SHIFT = 0; ZP = 0;
    got.delete();
    send(1, 1'b0);
    send(2, 1'b0);
    M0 = 5;
    send(3, 1'b0);
    send(4, 1'b1);
    send(3, 1'b1);
    idle(8);
    chk("cfg_nbeats", got.size(), 2);
    if (got.size() >= 2) begin
      chk("cfg_hold_data", got[0].data, 32'h04030201);
      chk("cfg_new_data", got[1].data, 32'h0000000F);
      chk("cfg_new_keep", got[1].keep, 4'h1);
    end

    // Random backpressure over 64 elements.
    M0 = 300; SHIFT = 12; ZP = 3;
    got.delete();
    bp_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send($urandom_range(0, 4000) - 2000, i == 63);
      if (i % 7 == 3) idle(1);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    @(posedge mm_clk);
    bp_en = 1'b0;
    #2 m_axis_tready = 1'b1;
    idle(20);
    chk("bp_nbeats", got.size(), 16);
    chk("bp_sb_empty", expq.size(), 0);

    // Reset mid-packet with a held output beat.
    M0 = 1; SHIFT = 0; ZP = 0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) send(i + 1, 1'b0);
    mon_en = 1'b0;
    s_axis_tvalid = 1'b0;
    mm_rst_n = 1'b0;
    @(posedge mm_clk); #1;
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_tkeep", m_axis_tkeep, 0);
    chk("mid_rst_tdata", m_axis_tdata, 0);
    chk("mid_rst_tlast", m_axis_tlast, 0);
    mm_rst_n = 1'b1;
    expq.delete(); pend.delete(); got.delete();
    model_first = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge mm_clk); #1;
    chk("post_rst_tready", s_axis_tready, 1);
    mon_en = 1'b1;
    send(7, 1'b0);
    send(9, 1'b1);
    idle(8);
    chk("post_rst_nbeats", got.size(), 1);
    if (got.size() >= 1) begin
      chk("post_rst_data", got[0].data, 32'h00000907);
      chk("post_rst_keep", got[0].keep, 4'h3);
      chk("post_rst_last", got[0].last, 1);
    end
    chk("post_rst_sb_empty", expq.size(), 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mm_requant_pack.md
# mm_requant_pack

Downstream stage of the matrix-multiply core. It consumes the core's 32-bit signed accumulator result stream and requantizes each element to int8 using integer-only arithmetic: multiply by a fixed-point scale, apply a rounding right shift, add a zero point, then saturate. It packs four int8 results per 32-bit output beat so the next layer's A/B input stream, or the DMA, receives dense int8 data. The block is fully pipelined at one element per cycle and propagates backpressure end to end.

## Interface
- D_W, 8: output element width (int8).
- D_W_ACC, 32: input accumulator width.
- PACK, 4: elements per output beat; PACK*D_W = 32.
- SHIFT_W, 6: width of the SHIFT config input.

- mm_clk  in  1  single clock for all logic.
- mm_rst_n  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  D_W_ACC  signed accumulator element.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last element of the result matrix.
- m_axis_tdata  out  32  packed int8 values; lane i is bits [8i+7:8i]; lane 0 holds the earliest element.
- m_axis_tkeep  out  4  byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last beat of the matrix.
- M0  in  32  signed scale multiplier.
- SHIFT  in  SHIFT_W  right-shift amount, 0..63.
- ZP  in  8  signed output zero point.

## Operation
- **Config latch.** M0, SHIFT and ZP are captured into internal registers on the first accepted input beat after reset or after an accepted tlast. They are held for the rest of the packet. Input changes mid-packet have no effect.
- **S1 (multiply).** prod = tdata * M0, computed as a 64-bit signed product.
- **S2 (round, shift, offset, saturate).**
  - If SHIFT = 0: r = prod.
  - Otherwise: r = (prod + (1 << (SHIFT-1))) >>> SHIFT. This is an arithmetic shift, so ties round toward +inf.
  - v = r + ZP, computed with 66-bit headroom.
  - Saturate v to [-128, 127].
  - S2 also carries the element's last flag.
- **Packer.**
  - A lane counter (0..PACK-1) writes each S2 result into the accumulating word.
  - When lane 3 is written, or a last-flagged element is written, the word moves to the output register:
    - tkeep = bits 0..lane set.
    - tlast = the element's last flag.
    - Unused lanes are 0x00.
  - The lane counter then returns to 0.
- Each of S1 and S2 has its own valid bit. Bubbles (tvalid low) do not advance the lane counter.

## Timing
- **Global stall:** stall = m_axis_tvalid & ~m_axis_tready.
- All pipeline registers and the packer advance only when stall is low.
- s_axis_tready = ~stall. This path is combinational from m_axis_tready.
- **Latency:** an element accepted at cycle t is in S1 at t+1 and in S2 at t+2. If it completes a word, m_axis_tvalid rises at t+3.
- Sustained throughput is 4 inputs per output beat with no bubbles when m_axis_tready is held high.
- The output register is loaded only when it is empty or is being accepted in the same cycle. A new word and acceptance of the old word in one cycle is a legal back-to-back transfer.
- m_axis_tdata, tkeep and tlast stay stable while tvalid is high and tready is low.
- **Reset (mm_rst_n low at a rising edge):**
  - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0.
  - Internal state: all valid bits = 0, lane counter = 0, config registers = 0.
  - s_axis_tready = 1 in the cycle after reset is released.
  - Reset mid-packet discards partial words and in-flight elements with no output.
- A tlast on lane 3 produces one beat with tkeep=1111 and tlast=1. No extra empty beat follows.
- A tlast while the pipeline is stalled is held in place until the stall clears.

## Structure
- Package mm_requant_pkg:
  - localparams D_W, D_W_ACC, PACK, PROD_W=64.
  - A function sat_int8(signed [65:0]) returning the clamped value.
- Sub-module rq_packer: the lane counter, word accumulator and output register with the AXI-S handshake.
- The S1/S2 arithmetic stays in the top module.

## Test plan
- M0=1, SHIFT=1, ZP=0; stream 2,4,6,8 with tlast on 8 -> one beat, tdata=0x04030201, tkeep=1111, tlast=1. tvalid first rises 3 cycles after the 4th element is accepted.
- M0=2^30, SHIFT=31, ZP=0; inputs 100, 1000, -1000, -3 (last) -> 0x32, 0x7F (saturated), 0x80 (saturated), 0xFF ((-3·2^30 + 2^30) >> 31 = -1).
- Rounding and ZP: M0=1, SHIFT=1, ZP=-5; inputs -3, 3, 0, 1 -> -6, -3, -5, -4, giving 0xFCFBFDFA.
- Partial tail: 5 elements with tlast on the 5th -> beat 1 tkeep=1111, tlast=0; beat 2 tkeep=0001, tlast=1, upper lanes 0.
- Backpressure: m_axis_tready random with 50% duty over 64 elements -> s_axis_tready follows ~stall. No element is lost or duplicated, and held output data stays stable; compare against a reference model.
- Config isolation and reset: change M0 mid-packet -> no effect until after tlast. Assert mm_rst_n low mid-packet -> tvalid=0 the next cycle, and the next packet starts cleanly at lane 0.
